// File: rtl/video_mux_pkg.sv
// Shared types for the frame-aligned video selector: FSM state encoding and
// the channel-index width helper.
package video_mux_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        LOCKED  = 2'd1,
        PEND    = 2'd2
    } mux_state_e;

    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/axi4_stream_skid.sv
// Two-entry AXI4-Stream register slice: registered outputs and a registered
// upstream ready, so the downstream ready never reaches the input side combinationally.
module axi4_stream_skid #(
    parameter int WIDTH = 18
) (
    input  logic             clk_i,
    input  logic             arst_n_i,
    input  logic [WIDTH-1:0] s_data_i,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i
);

    logic [WIDTH-1:0] skid_q;
    logic             skid_valid_q;
    logic             ready_q;
    logic             s_fire;
    logic             out_free;

    assign s_fire    = s_valid_i && ready_q;
    assign out_free  = !m_valid_o || m_ready_i;
    assign s_ready_o = ready_q;

    // ready_q is low in reset and whenever the spare entry holds a beat.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            m_data_o     <= '0;
            m_valid_o    <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
        end else if (out_free) begin
            ready_q <= 1'b1;
            if (skid_valid_q) begin
                m_data_o     <= skid_q;
                m_valid_o    <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (s_fire) begin
                m_data_o  <= s_data_i;
                m_valid_o <= 1'b1;
            end else begin
                m_valid_o <= 1'b0;
            end
        end else if (s_fire) begin
            skid_q       <= s_data_i;
            skid_valid_q <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            ready_q <= !skid_valid_q;
        end
    end

endmodule

// File: rtl/video_frame_mux.sv
// N-to-1 AXI4-Stream video selector that only changes source on a clean frame
// boundary; unselected cameras are drained or held according to DRAIN_UNSEL.
module video_frame_mux
    import video_mux_pkg::*;
#(
    parameter int  CHANNELS    = 2,
    parameter int  DATA_WIDTH  = 16,
    parameter int  DRAIN_UNSEL = 1,
    parameter int  FCNT_WIDTH  = 16,
    localparam int CW          = ch_width(CHANNELS)
) (
    input  logic                           clk_i,
    input  logic                           arst_n_i,
    input  logic [CW-1:0]                  sel_i,
    input  logic [CHANNELS*DATA_WIDTH-1:0] s_tdata_i,
    input  logic [CHANNELS-1:0]            s_tvalid_i,
    input  logic [CHANNELS-1:0]            s_tuser_i,
    input  logic [CHANNELS-1:0]            s_tlast_i,
    output logic [CHANNELS-1:0]            s_tready_o,
    output logic [DATA_WIDTH-1:0]          m_tdata_o,
    output logic                           m_tvalid_o,
    output logic                           m_tuser_o,
    output logic                           m_tlast_o,
    input  logic                           m_tready_i,
    output logic [CW-1:0]                  active_ch_o,
    output logic                           locked_o,
    output logic [FCNT_WIDTH-1:0]          frame_cnt_o,
    output mux_state_e                     state_o
);

    // Handshake: a beat moves on a port at a rising edge where tvalid and tready
    // are both high; tvalid never waits on tready, and a raised tvalid holds its
    // payload steady until taken. tready may depend on tvalid/tuser of that port.
    localparam logic DRAIN = (DRAIN_UNSEL != 0);

    mux_state_e            state_q, state_d;
    logic [CW-1:0]         sel_q, active_q, cur_ch;
    logic                  sel_ok, cur_ok, run_q, last_tlast_q;
    logic                  in_valid, in_user, in_last, push, take_switch, skid_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic [FCNT_WIDTH-1:0] fcnt_q;
    logic [DATA_WIDTH+1:0] m_payload;

    always_comb begin
        cur_ch   = (state_q == ACQUIRE) ? sel_q : active_q;
        sel_ok   = (int'(sel_q) < CHANNELS);
        cur_ok   = (int'(cur_ch) < CHANNELS);
        in_valid = cur_ok && s_tvalid_i[cur_ch];
        in_user  = s_tuser_i[cur_ch];
        in_last  = s_tlast_i[cur_ch];
        in_data  = s_tdata_i[cur_ch*DATA_WIDTH +: DATA_WIDTH];
        // A SOF that follows a completed line end is the only place a pending switch may land.
        take_switch = (state_q == PEND) && sel_ok && (sel_q != active_q)
                      && in_valid && in_user && last_tlast_q;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) state_q <= ACQUIRE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACQUIRE: if (push) state_d = LOCKED;
            LOCKED:  if (sel_ok && (sel_q != active_q)) state_d = PEND;
            PEND: begin
                if (!sel_ok || (sel_q == active_q)) state_d = LOCKED;
                else if (take_switch)               state_d = ACQUIRE;
            end
            default: state_d = ACQUIRE;
        endcase
    end

    always_comb begin
        s_tready_o = run_q ? {CHANNELS{DRAIN}} : '0;
        push       = 1'b0;
        case (state_q)
            ACQUIRE: if (cur_ok && run_q) begin
                s_tready_o[cur_ch] = in_user ? skid_ready : 1'b1;
                push               = in_valid && in_user && skid_ready;
            end
            LOCKED, PEND: begin
                s_tready_o[cur_ch] = skid_ready && !take_switch;
                push               = in_valid && skid_ready && !take_switch;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sel_q        <= '0;
            active_q     <= '0;
            run_q        <= 1'b0;
            last_tlast_q <= 1'b1;
            fcnt_q       <= '0;
        end else begin
            sel_q <= sel_i;
            run_q <= 1'b1;
            if (state_q == ACQUIRE && push) active_q <= cur_ch;
            if (push) last_tlast_q <= in_last;
            if (m_tvalid_o && m_tready_i && m_tuser_o) fcnt_q <= fcnt_q + FCNT_WIDTH'(1);
        end
    end

    axi4_stream_skid #(.WIDTH(DATA_WIDTH + 2)) u_skid (
        .clk_i     (clk_i),
        .arst_n_i  (arst_n_i),
        .s_data_i  ({in_user, in_last, in_data}),
        .s_valid_i (push),
        .s_ready_o (skid_ready),
        .m_data_o  (m_payload),
        .m_valid_o (m_tvalid_o),
        .m_ready_i (m_tready_i)
    );

    assign m_tuser_o   = m_payload[DATA_WIDTH+1];
    assign m_tlast_o   = m_payload[DATA_WIDTH];
    assign m_tdata_o   = m_payload[DATA_WIDTH-1:0];
    assign active_ch_o = active_q;
    assign locked_o    = (state_q != ACQUIRE);
    assign frame_cnt_o = fcnt_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_video_frame_mux.sv
// Randomised scoreboard bench for video_frame_mux: frame-level expectations are
// queued by the stimulus and popped by an independent output monitor.
`timescale 1ns/1ps
module tb_video_frame_mux;
    import video_mux_pkg::*;

    localparam int CH = 2;
    localparam int DW = 16;
    localparam int FW = 2;
    localparam int W  = DW + 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    logic [0:0]       sel = '0;
    logic [CH*DW-1:0] s_tdata = '0;
    logic [CH-1:0]    s_tvalid = '0, s_tuser = '0, s_tlast = '0;
    logic [CH-1:0]    s_tready, b_tready;
    logic [DW-1:0]    m_tdata, b_tdata;
    logic             m_tvalid, m_tuser, m_tlast, m_tready;
    logic             b_tvalid, b_tuser, b_tlast;
    logic [0:0]       active_ch, b_active;
    logic             locked, b_locked;
    logic [FW-1:0]    fcnt;
    logic [15:0]      b_fcnt;
    mux_state_e       st, b_st;

    video_frame_mux #(.CHANNELS(CH), .DATA_WIDTH(DW), .DRAIN_UNSEL(1), .FCNT_WIDTH(FW)) dut (
        .clk_i(clk), .arst_n_i(arst_n), .sel_i(sel),
        .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tuser_i(s_tuser), .s_tlast_i(s_tlast),
        .s_tready_o(s_tready),
        .m_tdata_o(m_tdata), .m_tvalid_o(m_tvalid), .m_tuser_o(m_tuser), .m_tlast_o(m_tlast),
        .m_tready_i(m_tready),
        .active_ch_o(active_ch), .locked_o(locked), .frame_cnt_o(fcnt), .state_o(st)
    );

    // Second instance in hold mode sharing the same input stimulus.
    video_frame_mux #(.CHANNELS(CH), .DATA_WIDTH(DW), .DRAIN_UNSEL(0), .FCNT_WIDTH(16)) dut_b (
        .clk_i(clk), .arst_n_i(arst_n), .sel_i(sel),
        .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tuser_i(s_tuser), .s_tlast_i(s_tlast),
        .s_tready_o(b_tready),
        .m_tdata_o(b_tdata), .m_tvalid_o(b_tvalid), .m_tuser_o(b_tuser), .m_tlast_o(b_tlast),
        .m_tready_i(1'b1),
        .active_ch_o(b_active), .locked_o(b_locked), .frame_cnt_o(b_fcnt), .state_o(b_st)
    );

    // ---------------- scoreboard state ----------------
    int            n_vec = 0;
    int            n_err = 0;
    logic [W-1:0]  exp_q[$];
    logic [FW-1:0] exp_fcnt = '0;
    int            stall_cnt = 0;
    logic          b_rdy1 = 1'b0;
    logic          bp_en = 1'b0;
    logic          hold_ready = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input int ch, input logic [DW-1:0] d, input logic u,
                             input logic l, input logic fwd);
        int   waits;
        logic hs;
        if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 2));
        s_tvalid[ch] = 1'b1;
        s_tuser[ch]  = u;
        s_tlast[ch]  = l;
        s_tdata[ch*DW +: DW] = d;
        waits = 0;
        hs    = 1'b0;
        while (!hs && waits < 200) begin
            @(negedge clk);
            hs     = s_tready[ch];
            b_rdy1 = b_tready[1];
            @(posedge clk);
            #1;
            if (!hs) waits++;
        end
        if (!hs) begin
            n_vec++;
            n_err++;
            $display("FAIL drv_timeout: ch %0d beat not taken after %0d cycles", ch, waits);
        end else if (fwd) begin
            exp_q.push_back({u, l, d});
        end
        s_tvalid[ch] = 1'b0;
        stall_cnt    = waits;
    endtask

    task automatic send_frame(input int ch, input int lines, input int px, input logic fwd);
        for (int y = 0; y < lines; y++)
            for (int x = 0; x < px; x++)
                send_beat(ch, 16'($urandom), (y == 0 && x == 0), (x == px - 1), fwd);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick(1);
            n++;
        end
        check("drain_queue", exp_q.size(), 0);
        tick(2);
    endtask

    // Output-side ready: fixed level or 50% random back-pressure.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_tready = bp_en ? 1'($urandom_range(0, 1)) : hold_ready;
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [W-1:0] beat, prev_beat, e;
        logic         prev_stall;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            beat = {m_tuser, m_tlast, m_tdata};
            if (prev_stall) begin
                check("stall_valid", m_tvalid, 1);
                check("stall_payload", beat, prev_beat);
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got %h expected none", beat);
                end else begin
                    e = exp_q.pop_front();
                    check("out_beat", beat, e);
                    if (m_tuser) begin
                        check("frame_cnt_seq", fcnt, exp_fcnt);
                        exp_fcnt = exp_fcnt + 1'b1;
                    end
                end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_beat  = beat;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        #12;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tuser", m_tuser, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_s_tready", s_tready, 0);
        check("rst_frame_cnt", fcnt, 0);
        check("rst_locked", locked, 0);
        check("rst_active_ch", active_ch, 0);
        @(posedge clk);
        #3 arst_n = 1'b1;
        tick(3);

        // Two full frames on ch0.
        send_frame(0, 4, 8, 1'b1);
        send_frame(0, 4, 8, 1'b1);
        wait_drain();
        check("p1_frame_cnt", fcnt, 2);
        check("p1_active_ch", active_ch, 0);
        check("p1_locked", locked, 1);

        // ch1 streams while ch0 is selected: drained here, held off in dut_b.
        for (int i = 0; i < 10; i++) begin
            send_beat(1, 16'($urandom), (i == 2), (i % 4 == 3), 1'b0);
            check("drain_unsel_ready", stall_cnt, 0);
            check("hold_unsel_ready", b_rdy1, 0);
        end
        tick(4);

        // Switch request mid-frame: ch0's frame completes, its next SOF is held then drained.
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++) begin
                if (y == 2 && x == 3) sel = 1'b1;
                send_beat(0, 16'($urandom), (y == 0 && x == 0), (x == 7), 1'b1);
            end
        send_beat(0, 16'($urandom), 1'b1, 1'b0, 1'b0);
        check("switch_hold_cycles", stall_cnt, 1);
        for (int i = 0; i < 3; i++) send_beat(1, 16'($urandom), 1'b0, (i == 1), 1'b0);
        send_frame(1, 2, 4, 1'b1);
        wait_drain();
        check("sw_active_ch", active_ch, 1);
        check("sw_locked", locked, 1);
        check("sw_frame_cnt", fcnt, 0);

        // Random back-pressure over one frame.
        bp_en = 1'b1;
        send_frame(1, 4, 8, 1'b1);
        wait_drain();
        bp_en = 1'b0;
        tick(2);
        check("bp_frame_cnt", fcnt, 1);

        // Truncated frame (no final tlast) followed by a fresh SOF: both forwarded.
        for (int i = 0; i < 6; i++) send_beat(1, 16'($urandom), (i == 0), (i == 3), 1'b1);
        send_frame(1, 2, 4, 1'b1);
        wait_drain();
        check("trunc_frame_cnt", fcnt, 3);
        check("trunc_active_ch", active_ch, 1);

        // Asynchronous reset with a beat stalled on the output.
        hold_ready = 1'b0;
        tick(2);
        send_beat(1, 16'($urandom), 1'b1, 1'b0, 1'b1);
        send_beat(1, 16'($urandom), 1'b0, 1'b0, 1'b1);
        tick(1);
        check("pre_rst_m_tvalid", m_tvalid, 1);
        #2 arst_n = 1'b0;
        #1;
        check("arst_m_tvalid", m_tvalid, 0);
        check("arst_frame_cnt", fcnt, 0);
        check("arst_s_tready", s_tready, 0);
        check("arst_locked", locked, 0);
        exp_q.delete();
        exp_fcnt = '0;
        #13 arst_n = 1'b1;
        hold_ready = 1'b1;
        @(posedge clk);
        #1;
        tick(3);
        // Remainder of the interrupted frame is discarded until the next SOF.
        for (int i = 0; i < 6; i++) send_beat(1, 16'($urandom), 1'b0, (i == 1 || i == 5), 1'b0);
        tick(3);
        check("post_rst_locked", locked, 0);
        check("post_rst_m_tvalid", m_tvalid, 0);

        // Five frames: counter walks 1,2,3,0,1.
        for (int f = 0; f < 5; f++) send_frame(1, 2, 4, 1'b1);
        wait_drain();
        check("wrap_frame_cnt", fcnt, 1);
        check("wrap_locked", locked, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
